// File: rtl/upg_dump_tx_pkg.sv
// Shared constants and types for the UART programmer (transmit dump and receive sides).
package upg_dump_tx_pkg;

  // 10 MHz clock / 128000 baud
  localparam int UPG_CLKS_PER_BIT = 78;

  // 8N1 frame: start + 8 data + stop
  localparam int UPG_BITS_PER_FRAME = 10;

  // Receive side: sample each bit at its midpoint, expect the same framing
  localparam int UPG_RX_SAMPLE_MID  = UPG_CLKS_PER_BIT / 2;
  localparam int UPG_RX_DATA_BITS   = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_CAPTURE,
    ST_SEND,
    ST_DONE
  } dump_state_e;

endpackage

// File: rtl/upg_dump_tx_uart_tx_byte.sv
// 8N1 byte serializer. ready_o is also high in the last cycle of the stop
// bit so a new byte can be loaded with no idle gap on the line.
module uart_tx_byte
  import upg_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UPG_CLKS_PER_BIT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] data_i,
  output logic       ready_o,
  output logic       tx_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] baud_q;
  logic [3:0]    bit_q;
  logic [9:0]    shreg_q;
  logic          active_q;
  logic          bit_end;
  logic          last_cyc;

  assign bit_end  = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign last_cyc = bit_end && (bit_q == 4'd9);
  assign ready_o  = !active_q || last_cyc;
  assign tx_o     = active_q ? shreg_q[0] : 1'b1;

  // Frame shifter and baud counter; a load in the final stop cycle restarts the frame
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= '1;
      active_q <= 1'b0;
    end else if (load_i && ready_o) begin
      baud_q   <= '0;
      bit_q    <= '0;
      shreg_q  <= {1'b1, data_i, 1'b0};
      active_q <= 1'b1;
    end else if (active_q) begin
      if (bit_end) begin
        baud_q  <= '0;
        bit_q   <= bit_q + 4'd1;
        shreg_q <= {1'b1, shreg_q[9:1]};
        if (bit_q == 4'd9) active_q <= 1'b0;
      end else begin
        baud_q <= baud_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/upg_dump_tx.sv
// Memory dump transmitter: reads 32-bit words and sends them LSB byte first over UART.
module upg_dump_tx
  import upg_dump_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = UPG_CLKS_PER_BIT
) (
  input  logic        upg_clk_i,
  input  logic        upg_rst_i,
  input  logic        start_i,
  input  logic [14:0] base_adr_i,
  input  logic [14:0] word_cnt_i,
  output logic        mem_rd_o,
  output logic [14:0] mem_adr_o,
  input  logic [31:0] mem_dat_i,
  output logic        upg_tx_o,
  output logic        busy_o,
  output logic        done_o
);

  dump_state_e state_q, state_d;
  logic [14:0] addr_q;
  logic [14:0] cnt_q;
  logic [31:0] word_q;
  logic [1:0]  byte_q;   // next byte of word_q to load; 0 means all four loaded
  logic        tx_load;
  logic [7:0]  tx_data;
  logic        tx_ready;

  uart_tx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_i   (upg_clk_i),
    .rst_i   (upg_rst_i),
    .load_i  (tx_load),
    .data_i  (tx_data),
    .ready_o (tx_ready),
    .tx_o    (upg_tx_o)
  );

  assign mem_adr_o = addr_q;
  assign busy_o    = (state_q == ST_FETCH) || (state_q == ST_CAPTURE) || (state_q == ST_SEND);

  // State register
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  // Next state and strobes; byte 0 is loaded straight from the read data so the
  // start bit appears the cycle after capture
  always_comb begin
    state_d  = state_q;
    mem_rd_o = 1'b0;
    done_o   = 1'b0;
    tx_load  = 1'b0;
    tx_data  = word_q[{byte_q, 3'b000} +: 8];
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) state_d = (word_cnt_i == 15'd0) ? ST_DONE : ST_FETCH;
      end
      ST_FETCH: begin
        mem_rd_o = 1'b1;
        state_d  = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tx_load = 1'b1;
        tx_data = mem_dat_i[7:0];
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (byte_q != 2'd0) tx_load = 1'b1;
          else                state_d = (cnt_q == 15'd1) ? ST_DONE : ST_FETCH;
        end
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Address, remaining count, word buffer and byte index
  always_ff @(posedge upg_clk_i) begin
    if (upg_rst_i) begin
      addr_q <= '0;
      cnt_q  <= '0;
      word_q <= '0;
      byte_q <= '0;
    end else begin
      if (state_q == ST_IDLE && start_i && word_cnt_i != 15'd0) begin
        addr_q <= base_adr_i;
        cnt_q  <= word_cnt_i;
      end
      if (state_q == ST_CAPTURE) begin
        word_q <= mem_dat_i;
        byte_q <= 2'd1;
      end
      if (state_q == ST_SEND && tx_ready) begin
        if (byte_q != 2'd0) begin
          byte_q <= byte_q + 2'd1;
        end else begin
          addr_q <= addr_q + 15'd1;
          cnt_q  <= cnt_q - 15'd1;
        end
      end
    end
  end

endmodule
